// File: rtl/y86_pkg.sv
// Shared Y86-64 decode constants: instruction codes, no-register marker, stack pointer index.
// Latency: n/a (constants only).  Backpressure: n/a.
package y86_pkg;
    localparam logic [3:0] IHALT   = 4'h0;
    localparam logic [3:0] INOP    = 4'h1;
    localparam logic [3:0] IRRMOVQ = 4'h2;
    localparam logic [3:0] IIRMOVQ = 4'h3;
    localparam logic [3:0] IRMMOVQ = 4'h4;
    localparam logic [3:0] IMRMOVQ = 4'h5;
    localparam logic [3:0] IOPQ    = 4'h6;
    localparam logic [3:0] IJXX    = 4'h7;
    localparam logic [3:0] ICALL   = 4'h8;
    localparam logic [3:0] IRET    = 4'h9;
    localparam logic [3:0] IPUSHQ  = 4'hA;
    localparam logic [3:0] IPOPQ   = 4'hB;

    localparam logic [3:0] RNONE   = 4'hF;
    localparam logic [3:0] RRSP    = 4'h4;

    localparam int         NUM_REGS = 15;
endpackage

// File: rtl/reg_file_array.sv
// 15-entry register storage with two write ports (M wins over E) and two async read ports.
// Latency: writes land on the rising edge, reads are combinational.  Backpressure: none.
module reg_file_array
    import y86_pkg::*;
#(
    parameter int DATA_W = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [3:0]        dstE,
    input  logic [3:0]        dstM,
    input  logic [DATA_W-1:0] valE,
    input  logic [DATA_W-1:0] valM,
    input  logic [3:0]        rd_a_idx,
    input  logic [3:0]        rd_b_idx,
    output logic [DATA_W-1:0] rd_a_dat,
    output logic [DATA_W-1:0] rd_b_dat
);
    logic [DATA_W-1:0] regs_q [NUM_REGS];
    logic [DATA_W-1:0] regs_d [NUM_REGS];

    // RNONE never matches an entry, so writes to index 15 fall through untouched.
    always_comb begin
        for (int i = 0; i < NUM_REGS; i++) begin
            regs_d[i] = regs_q[i];
            if (dstM == 4'(i)) begin
                regs_d[i] = valM;
            end else if (dstE == 4'(i)) begin
                regs_d[i] = valE;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

    assign rd_a_dat = (rd_a_idx == RNONE) ? '0 : regs_q[rd_a_idx];
    assign rd_b_dat = (rd_b_idx == RNONE) ? '0 : regs_q[rd_b_idx];
endmodule

// File: rtl/reg_file_decode.sv
// Y86 decode stage: picks srcA/srcB from icode and reads operands; REGFILE_BYPASS_EN forwards write-back data.
// Latency: reads combinational, writes visible after the next rising edge.  Backpressure: none.
module reg_file_decode
    import y86_pkg::*;
#(
    parameter int         DATA_W  = 64,
    parameter logic [3:0] RSP_IDX = RRSP
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [3:0]        icode,
    input  logic [3:0]        rA,
    input  logic [3:0]        rB,
    input  logic [3:0]        dstE,
    input  logic [3:0]        dstM,
    input  logic [DATA_W-1:0] valE,
    input  logic [DATA_W-1:0] valM,
    output logic [3:0]        srcA,
    output logic [3:0]        srcB,
    output logic [DATA_W-1:0] valA,
    output logic [DATA_W-1:0] valB
);
    logic [DATA_W-1:0] rd_a_dat;
    logic [DATA_W-1:0] rd_b_dat;

    always_comb begin
        srcA = RNONE;
        case (icode)
            IRRMOVQ, IRMMOVQ, IOPQ, IPUSHQ: srcA = rA;
            IRET, IPOPQ:                    srcA = RSP_IDX;
            default:                        srcA = RNONE;
        endcase
    end

    always_comb begin
        srcB = RNONE;
        case (icode)
            IRMMOVQ, IMRMOVQ, IOPQ:      srcB = rB;
            ICALL, IRET, IPUSHQ, IPOPQ:  srcB = RSP_IDX;
            default:                     srcB = RNONE;
        endcase
    end

    reg_file_array #(
        .DATA_W (DATA_W)
    ) u_array (
        .clk      (clk),
        .reset    (reset),
        .dstE     (dstE),
        .dstM     (dstM),
        .valE     (valE),
        .valM     (valM),
        .rd_a_idx (srcA),
        .rd_b_idx (srcB),
        .rd_a_dat (rd_a_dat),
        .rd_b_dat (rd_b_dat)
    );

`ifdef REGFILE_BYPASS_EN
    // Same M-over-E priority as the array so a forwarded value matches what gets stored.
    function automatic logic [DATA_W-1:0] fwd(input logic [3:0] src,
                                              input logic [DATA_W-1:0] stored);
        logic [DATA_W-1:0] res;
        res = stored;
        if (!reset && src != RNONE) begin
            if (src == dstM) begin
                res = valM;
            end else if (src == dstE) begin
                res = valE;
            end
        end
        return res;
    endfunction

    always_comb begin
        valA = fwd(srcA, rd_a_dat);
        valB = fwd(srcB, rd_b_dat);
    end
`else
    always_comb begin
        valA = rd_a_dat;
        valB = rd_b_dat;
    end
`endif
endmodule

// File: tb/tb_reg_file_decode.sv
// Directed scoreboard bench for reg_file_decode; builds with or without REGFILE_BYPASS_EN.
module tb_reg_file_decode;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  icode = 4'h0, rA = 4'h0, rB = 4'h0, dstE = 4'hF, dstM = 4'hF;
    logic [63:0] valE = '0, valM = '0;
    logic [3:0]  srcA, srcB;
    logic [63:0] valA, valB;

    always #5 clk = ~clk;

    reg_file_decode #(.DATA_W(64), .RSP_IDX(4'h4)) dut (
        .clk(clk), .reset(reset), .icode(icode), .rA(rA), .rB(rB),
        .dstE(dstE), .dstM(dstM), .valE(valE), .valM(valM),
        .srcA(srcA), .srcB(srcB), .valA(valA), .valB(valB)
    );

    typedef struct {
        string       name;
        logic [3:0]  sa;
        logic [3:0]  sb;
        logic [63:0] va;
        logic [63:0] vb;
    } exp_t;

    exp_t exp_q[$];
    logic chk_vld = 1'b0;
    logic stim_done = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;

    // Pick the expected read value depending on whether forwarding is built in.
    function automatic logic [63:0] bp(input logic [63:0] fwd_val, input logic [63:0] stored);
`ifdef REGFILE_BYPASS_EN
        return fwd_val;
`else
        return stored;
`endif
    endfunction

    task automatic step(input string name, input logic rst, input logic pulse_rst,
                        input logic [3:0] ic, input logic [3:0] a, input logic [3:0] b,
                        input logic [3:0] de, input logic [63:0] ve,
                        input logic [3:0] dm, input logic [63:0] vm,
                        input logic [3:0] esa, input logic [3:0] esb,
                        input logic [63:0] eva, input logic [63:0] evb);
        exp_t e;
        @(posedge clk);
        #1;
        reset = rst; icode = ic; rA = a; rB = b;
        dstE = de; valE = ve; dstM = dm; valM = vm;
        if (pulse_rst) begin
            #2 reset = 1'b1;
        end
        e.name = name; e.sa = esa; e.sb = esb; e.va = eva; e.vb = evb;
        exp_q.push_back(e);
        chk_vld = 1'b1;
    endtask

    // Monitor: compares whatever the DUT shows at the falling edge against the queued expectation.
    always @(negedge clk) begin
        if (chk_vld) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL scoreboard_underflow: check strobe with no expectation queued");
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                n_checks++;
                if (srcA !== e.sa) begin
                    n_fail++;
                    $display("FAIL %s srcA: got %h want %h", e.name, srcA, e.sa);
                end
                n_checks++;
                if (srcB !== e.sb) begin
                    n_fail++;
                    $display("FAIL %s srcB: got %h want %h", e.name, srcB, e.sb);
                end
                n_checks++;
                if (valA !== e.va) begin
                    n_fail++;
                    $display("FAIL %s valA: got %h want %h", e.name, valA, e.va);
                end
                n_checks++;
                if (valB !== e.vb) begin
                    n_fail++;
                    $display("FAIL %s valB: got %h want %h", e.name, valB, e.vb);
                end
            end
        end
    end

    function automatic logic [3:0] exp_srcA(input logic [3:0] ic);
        case (ic)
            4'h2, 4'h4, 4'h6, 4'hA: return 4'h7;
            4'h9, 4'hB:             return 4'h4;
            default:                return 4'hF;
        endcase
    endfunction

    function automatic logic [3:0] exp_srcB(input logic [3:0] ic);
        case (ic)
            4'h4, 4'h5, 4'h6:       return 4'h8;
            4'h8, 4'h9, 4'hA, 4'hB: return 4'h4;
            default:                return 4'hF;
        endcase
    endfunction

    function automatic logic [63:0] reg_val(input logic [3:0] idx);
        case (idx)
            4'h4:    return 64'hBB;
            4'h7:    return 64'h70;
            4'h8:    return 64'h80;
            default: return 64'h0;
        endcase
    endfunction

    logic [63:0] stored_tbl [15];

    initial begin
        stored_tbl = '{64'h0, 64'h11, 64'h22, 64'h1234, 64'hBB, 64'h0, 64'h0, 64'h0,
                       64'h0, 64'h0, 64'h0, 64'h0, 64'h0, 64'h0, 64'h0};

        // Reset: outputs zero, bypass suppressed, coincident write dropped.
        step("reset_read", 1, 0, 4'h6, 4'h0, 4'h3, 4'h3, 64'h77, 4'hF, 0,
             4'h0, 4'h3, 64'h0, 64'h0);
        step("write_r3", 0, 0, 4'h6, 4'h3, 4'h3, 4'h3, 64'h1234, 4'hF, 0,
             4'h3, 4'h3, bp(64'h1234, 64'h0), bp(64'h1234, 64'h0));
        step("read_r3", 0, 0, 4'h6, 4'h0, 4'h3, 4'hF, 0, 4'hF, 0,
             4'h0, 4'h3, 64'h0, 64'h1234);
        step("collide_wr", 0, 0, 4'h1, 4'h0, 4'h0, 4'h4, 64'hAA, 4'h4, 64'hBB,
             4'hF, 4'hF, 64'h0, 64'h0);
        step("popq_read", 0, 0, 4'hB, 4'h0, 4'h0, 4'hF, 0, 4'hF, 0,
             4'h4, 4'h4, 64'hBB, 64'hBB);
        step("dual_wr", 0, 0, 4'h0, 4'h0, 4'h0, 4'h1, 64'h11, 4'h2, 64'h22,
             4'hF, 4'hF, 64'h0, 64'h0);
        step("dual_read", 0, 0, 4'h6, 4'h1, 4'h2, 4'hF, 0, 4'hF, 0,
             4'h1, 4'h2, 64'h11, 64'h22);
        step("rnone_wr", 0, 0, 4'h0, 4'h0, 4'h0, 4'hF, 64'hFFFF, 4'hF, 64'hFFFF,
             4'hF, 4'hF, 64'h0, 64'h0);
        for (int r = 0; r < 15; r++) begin
            step($sformatf("scan_r%0d", r), 0, 0, 4'h6, 4'(r), 4'(r), 4'hF, 0, 4'hF, 0,
                 4'(r), 4'(r), stored_tbl[r], stored_tbl[r]);
        end

        // Icode decode sweep with distinct values in r7/r8.
        step("load_r7_r8", 0, 0, 4'h0, 4'h0, 4'h0, 4'h7, 64'h70, 4'h8, 64'h80,
             4'hF, 4'hF, 64'h0, 64'h0);
        for (int ic = 0; ic < 16; ic++) begin
            step($sformatf("icode_%h", ic), 0, 0, 4'(ic), 4'h7, 4'h8, 4'hF, 0, 4'hF, 0,
                 exp_srcA(4'(ic)), exp_srcB(4'(ic)),
                 reg_val(exp_srcA(4'(ic))), reg_val(exp_srcB(4'(ic))));
        end

        // Same-cycle forwarding: M match, E match, and M-over-E.
        step("byp_m", 0, 0, 4'h2, 4'h2, 4'h0, 4'hF, 0, 4'h2, 64'h55,
             4'h2, 4'hF, bp(64'h55, 64'h22), 64'h0);
        step("byp_m_after", 0, 0, 4'h2, 4'h2, 4'h0, 4'hF, 0, 4'hF, 0,
             4'h2, 4'hF, 64'h55, 64'h0);
        step("byp_e", 0, 0, 4'h2, 4'h1, 4'h0, 4'h1, 64'h99, 4'h5, 64'h66,
             4'h1, 4'hF, bp(64'h99, 64'h11), 64'h0);
        step("byp_e_after", 0, 0, 4'h6, 4'h1, 4'h5, 4'hF, 0, 4'hF, 0,
             4'h1, 4'h5, 64'h99, 64'h66);
        step("byp_prio", 0, 0, 4'h2, 4'h1, 4'h0, 4'h1, 64'h1, 4'h1, 64'h2,
             4'h1, 4'hF, bp(64'h2, 64'h99), 64'h0);
        step("byp_prio_after", 0, 0, 4'h6, 4'h1, 4'h2, 4'hF, 0, 4'hF, 0,
             4'h1, 4'h2, 64'h2, 64'h55);

        // Async reset mid-cycle with a pending write: no clock edge before the check.
        step("async_rst", 0, 1, 4'h6, 4'h1, 4'h2, 4'h1, 64'h123, 4'hF, 0,
             4'h1, 4'h2, 64'h0, 64'h0);
        step("post_rst", 0, 0, 4'h6, 4'h1, 4'h2, 4'hF, 0, 4'hF, 0,
             4'h1, 4'h2, 64'h0, 64'h0);

        @(posedge clk);
        #1 chk_vld = 1'b0;
        @(posedge clk);
        stim_done = 1'b1;
    end

    initial begin
        wait (stim_done);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d left, want 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: stimulus incomplete, want done by 50000");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/reg_file_decode.md
REG_FILE_DECODE -- requirements
Module: reg_file_decode

Interface
REQ-001 SHALL have parameter DATA_W, default 64, register/data width.
REQ-002 SHALL have parameter RSP_IDX, default 4, index of %rsp.
REQ-003 SHALL have port clk, input, 1, the only clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1, asynchronous, active-high; clears all state immediately.
REQ-005 SHALL have port icode, input, 4, instruction code of the instruction in decode.
REQ-006 SHALL have ports rA and rB, input, 4 each, register specifiers of the instruction in decode.
REQ-007 SHALL have port dstE, input, 4, write-back E destination; 4'hF means no write.
REQ-008 SHALL have port dstM, input, 4, write-back M destination; 4'hF means no write.
REQ-009 SHALL have ports valE and valM, input, DATA_W each, write-back data for dstE and dstM.
REQ-010 SHALL have ports srcA and srcB, output, 4 each, selected read indices (4'hF means none).
REQ-011 SHALL have ports valA and valB, output, DATA_W each, operand values read for decode.

Function
REQ-012 SHALL hold 15 registers of DATA_W bits, indices 0..14; index 15 (RNONE) is not storage.
REQ-013 SHALL set srcA = rA for icode 2, 4, 6 and A; RSP_IDX for icode 9 and B; RNONE otherwise.
REQ-014 SHALL set srcB = rB for icode 4, 5 and 6; RSP_IDX for icode 8, 9, A and B; RNONE otherwise.
REQ-015 SHALL drive valA/valB combinationally from the register at srcA/srcB, and 0 when the index is RNONE.
REQ-016 SHALL write valE to register dstE on a rising clk edge when dstE != RNONE.
REQ-017 SHALL write valM to register dstM on a rising clk edge when dstM != RNONE.
REQ-018 SHALL write both registers in the same edge when dstE and dstM differ and neither is RNONE.
REQ-019 SHALL write only valM when dstE == dstM != RNONE (M port has priority, as for popq %rsp).
REQ-020 SHALL have zero read latency: a write at edge N is visible on valA/valB after edge N.
REQ-021 SHALL ignore writes to index 15; no register changes and no X propagates.

Reset
REQ-022 SHALL clear all 15 registers to 0 asynchronously while reset is high, so valA = valB = 0.
REQ-023 SHALL suppress any write on a clk edge coincident with reset high; writes resume on the first edge after reset is low.
REQ-024 SHALL discard a write in progress when reset asserts mid-cycle; the register reads 0.

Configuration
REQ-025 SHALL support macro REGFILE_BYPASS_EN: when defined, a read whose src equals a non-RNONE dstM returns valM, else equal to dstE returns valE, in the same cycle; when undefined, reads return only stored values (REQ-020).
REQ-026 SHALL make bypass follow the M-over-E priority of REQ-019, and SHALL not bypass while reset is high.

Structure
REQ-027 SHALL take icode constants (IHALT..IPOPQ), RNONE = 4'hF and the %rsp index from shared package y86_pkg.
REQ-028 SHALL place storage and write ports in sub-module reg_file_array; src selection and bypass stay in reg_file_decode.

Verification
REQ-029 Reset: assert reset, icode=6, rA=0, rB=3 -> valA=0, valB=0; srcA=0, srcB=3.
REQ-030 Write/read: dstE=3, valE=64'h1234 for one edge; then icode=6, rB=3 -> valB=64'h1234, srcB=3.
REQ-031 Collision: dstE=dstM=4, valE=64'hAA, valM=64'hBB for one edge; then icode=B (popq) -> srcA=4, valA=64'hBB.
REQ-032 RNONE: dstE=dstM=4'hF, valE=64'hFFFF for one edge; then read all 15 registers -> all unchanged.
REQ-033 Bypass: with REGFILE_BYPASS_EN, dstM=2, valM=64'h55 and icode=2, rA=2 in the same cycle -> valA=64'h55 before the edge; without the macro -> old value, then 64'h55 after the edge.
REQ-034 Async reset: registers loaded with nonzero values, reset pulsed between edges -> valA/valB go to 0 without a clk edge.
